// File: rtl/cube_vertex_rotator.sv
// Rotates the eight vertices of an axis-aligned cube about Y using one latched
// sin/cos pair, applies an oblique projection and streams screen-space vertices.
`timescale 1ns/1ps
module cube_vertex_rotator #(
  parameter int TRIG_W    = 16,
  parameter int FRAC_BITS = 14,
  parameter int SIZE_W    = 8,
  parameter int CTR_W     = 10,
  parameter int SCR_W     = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic signed [TRIG_W-1:0] sin_in,
  input  logic signed [TRIG_W-1:0] cos_in,
  input  logic [SIZE_W-1:0]        half_size,
  input  logic [CTR_W-1:0]         center_x,
  input  logic [CTR_W-1:0]         center_y,
  output logic                     vtx_valid,
  input  logic                     vtx_ready,
  output logic [2:0]               vtx_idx,
  output logic signed [SCR_W-1:0]  vtx_x,
  output logic signed [SCR_W-1:0]  vtx_y,
  output logic                     busy,
  output logic                     done
);

  localparam int CRD_W  = SIZE_W + 1;
  localparam int PROD_W = CRD_W + TRIG_W;
  localparam int SUM_W  = PROD_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_ADD,
    S_OUT,
    S_DONE
  } state_t;

  state_t                    state_reg;
  logic signed [TRIG_W-1:0]  sin_reg;
  logic signed [TRIG_W-1:0]  cos_reg;
  logic [SIZE_W-1:0]         half_reg;
  logic [CTR_W-1:0]          cx_reg;
  logic [CTR_W-1:0]          cy_reg;
  logic [2:0]                idx_reg;
  logic signed [PROD_W-1:0]  xc_reg;
  logic signed [PROD_W-1:0]  zs_reg;
  logic signed [PROD_W-1:0]  xs_reg;
  logic signed [PROD_W-1:0]  zc_reg;

  // coord[0..2] = x, y, z of the current vertex; bit gi of idx picks +h or -h
  logic signed [CRD_W-1:0]   coord [3];
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_axis
      assign coord[gi] = idx_reg[gi] ? $signed({1'b0, half_reg})
                                     : -$signed({1'b0, half_reg});
    end
  endgenerate

  logic signed [SUM_W-1:0]   xsum_next;
  logic signed [SUM_W-1:0]   zsum_next;
  logic signed [SCR_W-1:0]   y_crd_next;
  logic [SCR_W-1:0]          x_next;
  logic [SCR_W-1:0]          y_next;

  assign xsum_next  = SUM_W'(xc_reg) + SUM_W'(zs_reg);
  assign zsum_next  = SUM_W'(zc_reg) - SUM_W'(xs_reg);
  assign y_crd_next = SCR_W'(coord[1]);
  // Sums wrap in SCR_W bits; clipping is the line drawer's job.
  assign x_next = SCR_W'(cx_reg) + SCR_W'(xsum_next >>> FRAC_BITS);
  assign y_next = SCR_W'(cy_reg) + y_crd_next
                + SCR_W'((zsum_next >>> FRAC_BITS) >>> 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      sin_reg   <= '0;
      cos_reg   <= '0;
      half_reg  <= '0;
      cx_reg    <= '0;
      cy_reg    <= '0;
      idx_reg   <= '0;
      xc_reg    <= '0;
      zs_reg    <= '0;
      xs_reg    <= '0;
      zc_reg    <= '0;
      vtx_valid <= 1'b0;
      vtx_idx   <= '0;
      vtx_x     <= '0;
      vtx_y     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            sin_reg   <= sin_in;
            cos_reg   <= cos_in;
            half_reg  <= half_size;
            cx_reg    <= center_x;
            cy_reg    <= center_y;
            idx_reg   <= '0;
            busy      <= 1'b1;
            state_reg <= S_MUL;
          end
        end
        S_MUL: begin
          xc_reg    <= PROD_W'(coord[0]) * PROD_W'(cos_reg);
          zs_reg    <= PROD_W'(coord[2]) * PROD_W'(sin_reg);
          xs_reg    <= PROD_W'(coord[0]) * PROD_W'(sin_reg);
          zc_reg    <= PROD_W'(coord[2]) * PROD_W'(cos_reg);
          state_reg <= S_ADD;
        end
        S_ADD: begin
          vtx_x     <= x_next;
          vtx_y     <= y_next;
          vtx_idx   <= idx_reg;
          vtx_valid <= 1'b1;
          state_reg <= S_OUT;
        end
        S_OUT: begin
          if (vtx_ready) begin
            vtx_valid <= 1'b0;
            if (idx_reg == 3'd7) begin
              done      <= 1'b1;
              state_reg <= S_DONE;
            end else begin
              idx_reg   <= idx_reg + 3'd1;
              state_reg <= S_MUL;
            end
          end
        end
        S_DONE: begin
          busy      <= 1'b0;
          state_reg <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cube_vertex_rotator.sv
// Directed and randomized bench for cube_vertex_rotator against an arithmetic
// model of the rotate-and-project equations.
`timescale 1ns/1ps
module tb_cube_vertex_rotator;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic signed [15:0] sin_in;
  logic signed [15:0] cos_in;
  logic [7:0]         half_size;
  logic [9:0]         center_x;
  logic [9:0]         center_y;
  logic               vtx_valid;
  logic               vtx_ready;
  logic [2:0]         vtx_idx;
  logic signed [11:0] vtx_x;
  logic signed [11:0] vtx_y;
  logic               busy;
  logic               done;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int m_sin, m_cos, m_h, m_cx, m_cy;
  int start_cyc;
  int cap_x [8];
  int cap_y [8];

  cube_vertex_rotator dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .sin_in    (sin_in),
    .cos_in    (cos_in),
    .half_size (half_size),
    .center_x  (center_x),
    .center_y  (center_y),
    .vtx_valid (vtx_valid),
    .vtx_ready (vtx_ready),
    .vtx_idx   (vtx_idx),
    .vtx_x     (vtx_x),
    .vtx_y     (vtx_y),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int obs, input int exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int floor_div(input longint a, input longint d);
    longint q;
    q = a / d;
    if ((a % d) != 0 && ((a < 0) != (d < 0))) q = q - 1;
    return int'(q);
  endfunction

  function automatic int wrap_scr(input int v);
    logic signed [11:0] t;
    t = v[11:0];
    return int'(t);
  endfunction

  task automatic expect_vertex(input int i, output int ex, output int ey);
    int x, y, z, xr, zr;
    x  = (i & 1) ? m_h : -m_h;
    y  = (i & 2) ? m_h : -m_h;
    z  = (i & 4) ? m_h : -m_h;
    xr = floor_div(longint'(x) * m_cos + longint'(z) * m_sin, 16384);
    zr = floor_div(longint'(z) * m_cos - longint'(x) * m_sin, 16384);
    ex = wrap_scr(m_cx + xr);
    ey = wrap_scr(m_cy + y + floor_div(zr, 2));
  endtask

  task automatic start_frame(input int s, input int c, input int h, input int cx, input int cy);
    @(negedge clk);
    sin_in = 16'(s); cos_in = 16'(c); half_size = 8'(h);
    center_x = 10'(cx); center_y = 10'(cy);
    m_sin = s; m_cos = c; m_h = h; m_cx = cx; m_cy = cy;
    start = 1'b1;
    @(posedge clk);
    #1;
    start_cyc = cyc;
    start = 1'b0;
    // scramble inputs so any failure to latch shows up
    sin_in = 16'($urandom); cos_in = 16'($urandom); half_size = 8'($urandom);
    center_x = 10'($urandom); center_y = 10'($urandom);
  endtask

  task automatic consume_vertex(input int i, input bit rand_ready, input string tag, output int hs);
    int ex, ey;
    bit got;
    got = 1'b0;
    hs = 0;
    expect_vertex(i, ex, ey);
    for (int k = 0; k < 60 && !got; k++) begin
      @(negedge clk);
      if (rand_ready) vtx_ready = ($urandom_range(0, 3) != 0);
      if (vtx_valid && vtx_ready) begin
        check($sformatf("%s_idx%0d", tag, i), int'(vtx_idx), i);
        check($sformatf("%s_x%0d", tag, i), int'(vtx_x), ex);
        check($sformatf("%s_y%0d", tag, i), int'(vtx_y), ey);
        check($sformatf("%s_busy%0d", tag, i), int'(busy), 1);
        cap_x[i] = int'(vtx_x);
        cap_y[i] = int'(vtx_y);
        hs = cyc + 1;
        got = 1'b1;
        @(posedge clk);
        #1;
      end
    end
    if (!got) check($sformatf("%s_timeout%0d", tag, i), int'(vtx_valid), 1);
  endtask

  task automatic finish_frame(input string tag);
    @(negedge clk);
    check({tag, "_done_hi"}, int'(done), 1);
    @(negedge clk);
    check({tag, "_done_lo"}, int'(done), 0);
    check({tag, "_busy_lo"}, int'(busy), 0);
  endtask

  task automatic run_frame(input string tag, input int s, input int c, input int h,
                           input int cx, input int cy, input bit rand_ready);
    int hs, prev;
    if (!rand_ready) vtx_ready = 1'b1;
    start_frame(s, c, h, cx, cy);
    prev = start_cyc;
    for (int i = 0; i < 8; i++) begin
      consume_vertex(i, rand_ready, tag, hs);
      if (!rand_ready) check($sformatf("%s_gap%0d", tag, i), hs - prev, 3);
      prev = hs;
    end
    finish_frame(tag);
  endtask

  task automatic wait_valid(input string tag);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      seen = vtx_valid;
    end
    if (!seen) check({tag, "_timeout"}, int'(vtx_valid), 1);
  endtask

  initial begin
    int hs, hs2, ex, ey, sx, sy;
    rst = 1'b1; start = 1'b0; vtx_ready = 1'b0;
    sin_in = '0; cos_in = '0; half_size = '0; center_x = '0; center_y = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", int'(vtx_valid), 0);
    check("rst_idx", int'(vtx_idx), 0);
    check("rst_x", int'(vtx_x), 0);
    check("rst_y", int'(vtx_y), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    rst = 1'b0;

    // Identity rotation
    run_frame("ident", 0, 16384, 100, 320, 240, 1'b0);
    check("ident_x0", cap_x[0], 220);
    check("ident_y0", cap_y[0], 90);
    check("ident_x7", cap_x[7], 420);
    check("ident_y7", cap_y[7], 390);

    // Quarter turn
    run_frame("quarter", 16384, 0, 100, 320, 240, 1'b0);
    check("quarter_x1", cap_x[1], 220);
    check("quarter_y1", cap_y[1], 90);
    check("quarter_x4", cap_x[4], 420);
    check("quarter_y4", cap_y[4], 190);

    // 45 degrees: floor truncation
    run_frame("trunc", 11585, 11585, 100, 320, 240, 1'b0);
    check("trunc_x0", cap_x[0], 178);
    check("trunc_y0", cap_y[0], 140);
    check("trunc_x7", cap_x[7], 461);
    check("trunc_y7", cap_y[7], 340);

    // Backpressure on idx2, then a stray start during idx4
    vtx_ready = 1'b1;
    start_frame(5000, 15000, 60, 200, 150);
    consume_vertex(0, 1'b0, "bp", hs);
    consume_vertex(1, 1'b0, "bp", hs);
    vtx_ready = 1'b0;
    wait_valid("bp_v2");
    expect_vertex(2, ex, ey);
    check("bp_idx2", int'(vtx_idx), 2);
    check("bp_x2", int'(vtx_x), ex);
    check("bp_y2", int'(vtx_y), ey);
    sx = int'(vtx_x);
    sy = int'(vtx_y);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("bp_hold_valid%0d", k), int'(vtx_valid), 1);
      check($sformatf("bp_hold_idx%0d", k), int'(vtx_idx), 2);
      check($sformatf("bp_hold_x%0d", k), int'(vtx_x), sx);
      check($sformatf("bp_hold_y%0d", k), int'(vtx_y), sy);
    end
    vtx_ready = 1'b1;
    hs2 = cyc + 1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("bp_single_hs", int'(vtx_valid), 0);
    consume_vertex(3, 1'b0, "bp", hs);
    check("bp_gap3", hs - hs2, 3);
    start = 1'b1;
    sin_in = -16'sd9000;
    consume_vertex(4, 1'b0, "bp", hs);
    start = 1'b0;
    for (int i = 5; i < 8; i++) consume_vertex(i, 1'b0, "bp", hs);
    finish_frame("bp");
    repeat (4) @(negedge clk);
    check("bp_no_restart_busy", int'(busy), 0);
    check("bp_no_restart_valid", int'(vtx_valid), 0);

    // Reset during OUT of idx5
    vtx_ready = 1'b1;
    start_frame(-7000, 14000, 90, 500, 300);
    for (int i = 0; i < 5; i++) consume_vertex(i, 1'b0, "rs", hs);
    vtx_ready = 1'b0;
    wait_valid("rs_v5");
    check("rs_idx5", int'(vtx_idx), 5);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rs_valid", int'(vtx_valid), 0);
    check("rs_idx", int'(vtx_idx), 0);
    check("rs_x", int'(vtx_x), 0);
    check("rs_y", int'(vtx_y), 0);
    check("rs_busy", int'(busy), 0);
    check("rs_done", int'(done), 0);
    vtx_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("rs_nodone%0d", k), int'(done), 0);
      check($sformatf("rs_idle%0d", k), int'(busy), 0);
    end
    run_frame("fresh", 3000, -16000, 45, 700, 100, 1'b0);

    // Degenerate geometry and trig
    run_frame("h0", 9000, -12000, 0, 333, 444, 1'b1);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("h0_cx%0d", i), cap_x[i], 333);
      check($sformatf("h0_cy%0d", i), cap_y[i], 444);
    end
    run_frame("trig0", 0, 0, 77, 400, 200, 1'b1);
    check("trig0_x3", cap_x[3], 400);
    check("trig0_y3", cap_y[3], 277);

    // Random frames with random backpressure
    for (int f = 0; f < 6; f++) begin
      run_frame($sformatf("rnd%0d", f),
                int'($urandom_range(0, 32768)) - 16384,
                int'($urandom_range(0, 32768)) - 16384,
                int'($urandom_range(0, 255)),
                int'($urandom_range(0, 1023)),
                int'($urandom_range(0, 1023)), 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
